// File: rtl/rxrsp_posq_if.sv
// rtl/rxrsp_posq_if.sv - RSP flit type and head-of-queue handshake interface
//
// rxrsp_posq_pkg : rspflit_t, the RSP flit carried by the link and the queue.
// rxrsp_posq_if  : head-of-queue handshake toward the rxrsp pipe slice.
//   pout_valid               head entry valid
//   pout_ready               slice accepts head entry
//   rxrsp_posq_first_entry_o head flit
//   modport master : queue side (drives valid/data, samples ready)
//   modport slave  : slice side (samples valid/data, drives ready)

package rxrsp_posq_pkg;
    typedef struct packed {
        logic [3:0] qos;
        logic [6:0] tgtid;
        logic [6:0] srcid;
        logic [7:0] txnid;
        logic [4:0] opcode;
        logic [2:0] resp;
        logic [7:0] dbid;
    } rspflit_t;
endpackage

interface rxrsp_posq_if;
    import rxrsp_posq_pkg::*;

    logic     pout_valid;
    logic     pout_ready;
    rspflit_t rxrsp_posq_first_entry_o;

    modport master (
        output pout_valid,
        output rxrsp_posq_first_entry_o,
        input  pout_ready
    );

    modport slave (
        input  pout_valid,
        input  rxrsp_posq_first_entry_o,
        output pout_ready
    );
endinterface

// File: rtl/rxrsp_posq.sv
// rtl/rxrsp_posq.sv - receive-side CHI RSP queue with link-credit FSM
//
// Optional feature macro: RXRSP_POSQ_BYPASS_EN (empty-queue same-cycle bypass).
//
// Ports:
//   clock          sole clock, rising edge
//   reset          asynchronous active-low reset
//   flush          drop all queued flits (synchronous)
//   crd_en_i       link active; permits credit grants
//   rxrsp_flitv_i  link flit valid (no back-pressure)
//   rxrsp_flit_i   incoming RSP flit
//   rxrsp_lcrdv_o  one link credit granted this cycle (registered)
//   pout           head-of-queue handshake (rxrsp_posq_if.master)
//   link_idle_o    credit FSM in STOP
//   err_ovf_o      sticky: flit arrived with no outstanding credit

module rxrsp_posq
    import rxrsp_posq_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               crd_en_i,
    input  logic               rxrsp_flitv_i,
    input  rspflit_t           rxrsp_flit_i,
    output logic               rxrsp_lcrdv_o,
    rxrsp_posq_if.master       pout,
    output logic               link_idle_o,
    output logic               err_ovf_o
);

    typedef enum logic [1:0] {S_STOP, S_RUN, S_DRAIN} state_t;

    state_t     r_state;
    logic       r_lcrdv;
    logic       r_idle;
    logic       r_err;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_crd_pend;
    logic [CNT_W-1:0] r_crd_out;
    rspflit_t   r_mem [DEPTH];

    logic w_enq;
    logic w_ovf;
    logic w_grant;
    logic w_empty;
    logic w_byp;
    logic w_push;
    logic w_pop;

    // A flit is only legal against an outstanding credit; otherwise it is dropped.
    assign w_enq   = rxrsp_flitv_i && (r_crd_out != '0);
    assign w_ovf   = rxrsp_flitv_i && (r_crd_out == '0);
    // crd_en_i gates the grant directly so a RUN->DRAIN cycle issues nothing.
    assign w_grant = (r_state == S_RUN) && crd_en_i && (r_crd_pend != '0);
    assign w_empty = (r_count == '0);

`ifdef RXRSP_POSQ_BYPASS_EN
    logic w_byp_vis;
    assign w_byp_vis = w_enq && w_empty && !flush;
    assign w_byp     = w_byp_vis && pout.pout_ready;
    assign pout.pout_valid = !w_empty || w_byp_vis;
    assign pout.rxrsp_posq_first_entry_o = w_empty ? rxrsp_flit_i : r_mem[r_rd_ptr];
`else
    assign w_byp = 1'b0;
    assign pout.pout_valid = !w_empty;
    assign pout.rxrsp_posq_first_entry_o = r_mem[r_rd_ptr];
`endif

    // A bypassed flit is consumed directly and never occupies a slot.
    assign w_push = w_enq && !w_byp;
    assign w_pop  = !w_empty && pout.pout_ready && !flush;

    assign rxrsp_lcrdv_o = r_lcrdv;
    assign link_idle_o   = r_idle;
    assign err_ovf_o     = r_err;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= rxrsp_flit_i;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_crd_pend <= CNT_W'(DEPTH);
            r_crd_out  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_push);
            // Flush discards everything older than the current write slot; a
            // flit enqueued in the same cycle survives at the old wr_ptr.
            if (flush) begin
                r_rd_ptr <= r_wr_ptr;
                r_count  <= CNT_W'(w_push);
            end else begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
                r_count  <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            end
            // Freed slots return to the pending pool; flushed entries return all at once.
            r_crd_pend <= r_crd_pend + (flush ? r_count : CNT_W'(w_pop))
                        + CNT_W'(w_byp) - CNT_W'(w_grant);
            r_crd_out  <= r_crd_out + CNT_W'(w_grant) - CNT_W'(w_enq);
            if (w_ovf) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_STOP;
            r_lcrdv <= 1'b0;
            r_idle  <= 1'b1;
        end else begin
            r_lcrdv <= w_grant;
            case (r_state)
                S_STOP: begin
                    if (crd_en_i) begin
                        r_state <= S_RUN;
                        r_idle  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (!crd_en_i) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (crd_en_i) begin
                        r_state <= S_RUN;
                    end else if (r_crd_out == '0) begin
                        r_state <= S_STOP;
                        r_idle  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_STOP;
                    r_idle  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rxrsp_posq.sv
// tb/tb_rxrsp_posq.sv - self-checking bench for rxrsp_posq

module tb_rxrsp_posq;
    import rxrsp_posq_pkg::*;

    localparam int DEPTH = 8;

    logic     clock;
    logic     reset;
    logic     flush;
    logic     crd_en_i;
    logic     rxrsp_flitv_i;
    rspflit_t rxrsp_flit_i;
    logic     rxrsp_lcrdv_o;
    logic     link_idle_o;
    logic     err_ovf_o;

    rxrsp_posq_if ifc ();

    rxrsp_posq #(.DEPTH(DEPTH)) dut (
        .clock         (clock),
        .reset         (reset),
        .flush         (flush),
        .crd_en_i      (crd_en_i),
        .rxrsp_flitv_i (rxrsp_flitv_i),
        .rxrsp_flit_i  (rxrsp_flit_i),
        .rxrsp_lcrdv_o (rxrsp_lcrdv_o),
        .pout          (ifc),
        .link_idle_o   (link_idle_o),
        .err_ovf_o     (err_ovf_o)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int       checks = 0;
    int       failures = 0;
    rspflit_t sb[$];
    int       link_cred = 0;
    int       pulse_cnt = 0;
    int       pop_cnt = 0;
    logic     exp_ovf = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic rspflit_t mk(input logic [7:0] tag);
        rspflit_t f;
        f       = '0;
        f.txnid = tag;
        f.dbid  = 8'($urandom);
        f.srcid = 7'($urandom);
        return f;
    endfunction

    // One clock: score the transfer about to happen, then check state after the edge.
    task automatic tick();
        rspflit_t e;
        #1;
        if (reset) begin
            if (flush) sb.delete();
            if (rxrsp_flitv_i) begin
                if (link_cred > 0) begin
                    sb.push_back(rxrsp_flit_i);
                    link_cred--;
                end else begin
                    exp_ovf = 1'b1;
                end
            end
            if (ifc.pout_valid && ifc.pout_ready && !flush) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'(ifc.rxrsp_posq_first_entry_o), 64'h0);
                    chk("sb_nonempty", 64'(sb.size()), 64'd1);
                end else begin
                    e = sb.pop_front();
                    chk("head_data", 64'(ifc.rxrsp_posq_first_entry_o), 64'(e));
                    pop_cnt++;
                end
            end
        end
        @(posedge clock);
        #1;
        if (rxrsp_lcrdv_o) begin
            link_cred++;
            pulse_cnt++;
        end
        chk("invariant", 64'(int'(dut.r_count) + int'(dut.r_crd_pend) + int'(dut.r_crd_out)), 64'(DEPTH));
        chk("crd_out", 64'(dut.r_crd_out), 64'(link_cred));
        chk("err_ovf", 64'(err_ovf_o), 64'(exp_ovf));
    endtask

    initial begin
        int sent;
        int pops0;
        reset         = 1'b1;
        flush         = 1'b0;
        crd_en_i      = 1'b1;
        rxrsp_flitv_i = 1'b0;
        rxrsp_flit_i  = '0;
        ifc.pout_ready = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("rst_lcrdv", 64'(rxrsp_lcrdv_o), 64'd0);
        chk("rst_valid", 64'(ifc.pout_valid), 64'd0);
        chk("rst_err", 64'(err_ovf_o), 64'd0);
        chk("rst_idle", 64'(link_idle_o), 64'd1);
        chk("rst_count", 64'(dut.r_count), 64'd0);
        chk("rst_pend", 64'(dut.r_crd_pend), 64'(DEPTH));
        chk("rst_out", 64'(dut.r_crd_out), 64'd0);
        tick();
        tick();
        reset = 1'b1;

        // Credit ramp: STOP->RUN, then DEPTH consecutive grants.
        tick();
        chk("run_idle", 64'(link_idle_o), 64'd0);
        chk("run_first_lcrdv", 64'(rxrsp_lcrdv_o), 64'd0);
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            chk("grant_pulse", 64'(rxrsp_lcrdv_o), 64'd1);
        end
        tick();
        chk("grant_end", 64'(rxrsp_lcrdv_o), 64'd0);
        chk("ramp_pend", 64'(dut.r_crd_pend), 64'd0);
        chk("ramp_out", 64'(dut.r_crd_out), 64'(DEPTH));

        // Fill to full with ready low, then drain in order.
        for (int i = 0; i < DEPTH; i++) begin
            rxrsp_flitv_i = 1'b1;
            rxrsp_flit_i  = mk(8'(8'h10 + i));
            tick();
        end
        rxrsp_flitv_i = 1'b0;
        tick();
        chk("full_count", 64'(dut.r_count), 64'(DEPTH));
        chk("full_valid", 64'(ifc.pout_valid), 64'd1);
        chk("full_head", 64'(ifc.rxrsp_posq_first_entry_o.txnid), 64'h10);
        pulse_cnt = 0;
        ifc.pout_ready = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) tick();
        ifc.pout_ready = 1'b0;
        chk("drain_pulses", 64'(pulse_cnt), 64'(DEPTH));
        chk("drain_sb_empty", 64'(sb.size()), 64'd0);
        chk("drain_valid", 64'(ifc.pout_valid), 64'd0);

        // Flush with a same-cycle enqueue and ready.
        for (int i = 0; i < 3; i++) begin
            rxrsp_flitv_i = 1'b1;
            rxrsp_flit_i  = mk(8'(8'h20 + i));
            tick();
        end
        chk("pre_flush_count", 64'(dut.r_count), 64'd3);
        pulse_cnt = 0;
        flush = 1'b1;
        rxrsp_flit_i = mk(8'h23);
        ifc.pout_ready = 1'b1;
        tick();
        flush = 1'b0;
        rxrsp_flitv_i = 1'b0;
        ifc.pout_ready = 1'b0;
        chk("flush_count", 64'(dut.r_count), 64'd1);
        chk("flush_head", 64'(ifc.rxrsp_posq_first_entry_o.txnid), 64'h23);
        for (int i = 0; i < 4; i++) tick();
        chk("flush_pulses", 64'(pulse_cnt), 64'd3);
        ifc.pout_ready = 1'b1;
        tick();
        ifc.pout_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("all_out", 64'(dut.r_crd_out), 64'(DEPTH));

        // Drain credits with the link disabled, then overflow.
        crd_en_i = 1'b0;
        pulse_cnt = 0;
        tick();
        chk("drain_idle", 64'(link_idle_o), 64'd0);
        for (int i = 0; i < DEPTH; i++) begin
            rxrsp_flitv_i = 1'b1;
            rxrsp_flit_i  = mk(8'(8'h30 + i));
            tick();
        end
        rxrsp_flitv_i = 1'b0;
        tick();
        chk("stop_idle", 64'(link_idle_o), 64'd1);
        chk("drain_no_grant", 64'(pulse_cnt), 64'd0);
        rxrsp_flitv_i = 1'b1;
        rxrsp_flit_i  = mk(8'h38);
        tick();
        rxrsp_flitv_i = 1'b0;
        tick();
        tick();
        chk("ovf_sticky", 64'(err_ovf_o), 64'd1);
        chk("ovf_count", 64'(dut.r_count), 64'(DEPTH));
        ifc.pout_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) tick();
        ifc.pout_ready = 1'b0;
        chk("stop_sb_empty", 64'(sb.size()), 64'd0);
        chk("stop_pend", 64'(dut.r_crd_pend), 64'(DEPTH));
        crd_en_i = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) tick();
        chk("regrant_pulses", 64'(pulse_cnt), 64'(DEPTH));

        // Wrap-around with random back-pressure.
        sent  = 0;
        pops0 = pop_cnt;
        for (int t = 0; t < 400 && (sent < 20 || sb.size() > 0); t++) begin
            rxrsp_flitv_i = (sent < 20) && (link_cred > 0) && ($urandom_range(0, 3) != 0);
            if (rxrsp_flitv_i) begin
                rxrsp_flit_i = mk(8'(8'h40 + sent));
                sent++;
            end
            ifc.pout_ready = 1'($urandom_range(0, 1));
            tick();
        end
        rxrsp_flitv_i = 1'b0;
        ifc.pout_ready = 1'b0;
        chk("wrap_sent", 64'(sent), 64'd20);
        chk("wrap_popped", 64'(pop_cnt - pops0), 64'd20);
        for (int i = 0; i < 4; i++) tick();

        // Empty-queue latency (same cycle with bypass, next cycle without).
        rxrsp_flitv_i = 1'b1;
        rxrsp_flit_i  = mk(8'h5A);
        ifc.pout_ready = 1'b1;
        #1;
`ifdef RXRSP_POSQ_BYPASS_EN
        chk("byp_valid", 64'(ifc.pout_valid), 64'd1);
        chk("byp_head", 64'(ifc.rxrsp_posq_first_entry_o.txnid), 64'h5A);
        tick();
        rxrsp_flitv_i = 1'b0;
        chk("byp_count", 64'(dut.r_count), 64'd0);
`else
        chk("nobyp_valid0", 64'(ifc.pout_valid), 64'd0);
        ifc.pout_ready = 1'b0;
        tick();
        rxrsp_flitv_i = 1'b0;
        chk("nobyp_valid1", 64'(ifc.pout_valid), 64'd1);
        chk("nobyp_head", 64'(ifc.rxrsp_posq_first_entry_o.txnid), 64'h5A);
        chk("nobyp_count", 64'(dut.r_count), 64'd1);
        ifc.pout_ready = 1'b1;
        tick();
`endif
        ifc.pout_ready = 1'b0;
        tick();
        chk("lat_sb_empty", 64'(sb.size()), 64'd0);

        // Reset mid-operation with data queued and the error flag forced.
        rxrsp_flitv_i = 1'b1;
        rxrsp_flit_i  = mk(8'h60);
        tick();
        rxrsp_flit_i  = mk(8'h61);
        tick();
        rxrsp_flitv_i = 1'b0;
        #2 reset = 1'b0;
        #1;
        sb.delete();
        link_cred = 0;
        exp_ovf = 1'b0;
        chk("mid_rst_count", 64'(dut.r_count), 64'd0);
        chk("mid_rst_valid", 64'(ifc.pout_valid), 64'd0);
        chk("mid_rst_lcrdv", 64'(rxrsp_lcrdv_o), 64'd0);
        chk("mid_rst_idle", 64'(link_idle_o), 64'd1);
        chk("mid_rst_pend", 64'(dut.r_crd_pend), 64'(DEPTH));
        tick();
        chk("mid_rst_hold_lcrdv", 64'(rxrsp_lcrdv_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
